// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/refresh for the four segment registers,
// load-use and memory-wait detection, and multi-cycle mult/div sequencing.
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 2,
  parameter int DIV_CYCLES  = 33,
  parameter int REG_W       = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rs_ren,
  input  logic             id_rt_ren,
  input  logic             ex_load,
  input  logic             ex_regwen,
  input  logic [REG_W-1:0] ex_wreg,
  input  logic             ex_mult,
  input  logic             ex_div,
  input  logic             i_stall,
  input  logic             d_stall,
  input  logic             exc_flush,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             mem_wb_stall,
  output logic             if_id_refresh,
  output logic             id_ex_refresh,
  output logic             ex_mem_refresh,
  output logic             mem_wb_refresh,
  output logic             md_start,
  output logic             md_busy
);

  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MUL_LD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] md_ld;
  logic          md_go;
  logic          load_use;
  logic [3:0]    stall;
  logic [3:0]    refresh;

  assign md_ld = ex_div ? DIV_LD : MUL_LD;
  assign md_go = (state_q == S_IDLE) & (ex_mult | ex_div)
               & ~exc_flush & ~d_stall;

  assign md_start = resetn & md_go;
  assign md_busy  = resetn & (md_go | (state_q == S_BUSY));

  assign load_use = ex_load & ex_regwen & (ex_wreg != '0)
                  & ((id_rs_ren & (id_rs == ex_wreg))
                   | (id_rt_ren & (id_rt == ex_wreg)));

  // Launch cycle is the first busy cycle, so BUSY covers the remaining N-1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (exc_flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (md_go) begin
            cnt_q   <= md_ld;
            state_q <= (md_ld == '0) ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          if (!d_stall) begin
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_q <= S_DONE;
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Bit order: {if_id, id_ex, ex_mem, mem_wb}
  always_comb begin
    stall   = '0;
    refresh = '0;
    if (!resetn) begin
      refresh = 4'b1111;
    end else if (exc_flush) begin
      refresh = 4'b1111;
    end else if (d_stall) begin
      stall = 4'b1111;
    end else if (md_busy) begin
      stall   = 4'b1100;
      refresh = 4'b0010;
    end else if (load_use) begin
      stall   = 4'b1000;
      refresh = 4'b0100;
    end else if (i_stall) begin
      refresh = 4'b1000;
    end
  end

  assign if_id_stall    = stall[3];
  assign id_ex_stall    = stall[2];
  assign ex_mem_stall   = stall[1];
  assign mem_wb_stall   = stall[0];
  assign if_id_refresh  = refresh[3];
  assign id_ex_refresh  = refresh[2];
  assign ex_mem_refresh = refresh[1];
  assign mem_wb_refresh = refresh[0];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: hazard rows, mult/div timing,
// flush and asynchronous reset behaviour.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic [5:0] id_rs, id_rt, ex_wreg;
  logic       id_rs_ren, id_rt_ren, ex_load, ex_regwen;
  logic       ex_mult, ex_div, i_stall, d_stall, exc_flush;
  logic       if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic       if_id_refresh, id_ex_refresh, ex_mem_refresh, mem_wb_refresh;
  logic       md_start, md_busy;

  int n_chk  = 0;
  int n_fail = 0;
  int busy_n;

  // {md_start, md_busy, stall[if_id..mem_wb], refresh[if_id..mem_wb]}
  localparam logic [9:0] E_RST   = 10'b00_0000_1111;
  localparam logic [9:0] E_NONE  = 10'b00_0000_0000;
  localparam logic [9:0] E_LU    = 10'b00_1000_0100;
  localparam logic [9:0] E_IST   = 10'b00_0000_1000;
  localparam logic [9:0] E_START = 10'b11_1100_0010;
  localparam logic [9:0] E_BUSY  = 10'b01_1100_0010;
  localparam logic [9:0] E_BDST  = 10'b01_1111_0000;
  localparam logic [9:0] E_BFLS  = 10'b01_0000_1111;
  localparam logic [9:0] E_FLS   = 10'b00_0000_1111;

  wire [9:0] obs = {md_start, md_busy,
                    if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
                    if_id_refresh, id_ex_refresh, ex_mem_refresh,
                    mem_wb_refresh};

  pipe_hazard_ctrl #(
    .MULT_CYCLES(2),
    .DIV_CYCLES (33),
    .REG_W      (6)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rs_ren     (id_rs_ren),
    .id_rt_ren     (id_rt_ren),
    .ex_load       (ex_load),
    .ex_regwen     (ex_regwen),
    .ex_wreg       (ex_wreg),
    .ex_mult       (ex_mult),
    .ex_div        (ex_div),
    .i_stall       (i_stall),
    .d_stall       (d_stall),
    .exc_flush     (exc_flush),
    .if_id_stall   (if_id_stall),
    .id_ex_stall   (id_ex_stall),
    .ex_mem_stall  (ex_mem_stall),
    .mem_wb_stall  (mem_wb_stall),
    .if_id_refresh (if_id_refresh),
    .id_ex_refresh (id_ex_refresh),
    .ex_mem_refresh(ex_mem_refresh),
    .mem_wb_refresh(mem_wb_refresh),
    .md_start      (md_start),
    .md_busy       (md_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got[9:0], exp[9:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_rs = '0; id_rt = '0; ex_wreg = '0;
    id_rs_ren = 0; id_rt_ren = 0; ex_load = 0; ex_regwen = 0;
    ex_mult = 0; ex_div = 0; i_stall = 0; d_stall = 0; exc_flush = 0;
  endtask

  task automatic flush_fsm();
    clr();
    exc_flush = 1;
    step();
    exc_flush = 0;
  endtask

  initial begin
    clr();
    resetn = 0;
    ex_div = 1; d_stall = 1; i_stall = 1;
    #3 chk("rst_async", obs, E_RST);
    step();
    chk("rst_hold", obs, E_RST);
    clr();
    resetn = 1;
    #1 chk("idle", obs, E_NONE);
    step();

    // load-use via rs, then cleared
    ex_load = 1; ex_regwen = 1; ex_wreg = 5; id_rs = 5; id_rs_ren = 1;
    #1 chk("lu_rs", obs, E_LU);
    step();
    ex_load = 0;
    #1 chk("lu_clr", obs, E_NONE);
    ex_load = 1; ex_wreg = 0; id_rs = 0;
    #1 chk("lu_r0", obs, E_NONE);
    ex_wreg = 7; id_rs = 5; id_rt = 7; id_rt_ren = 1;
    #1 chk("lu_rt", obs, E_LU);
    ex_regwen = 0;
    #1 chk("lu_nowen", obs, E_NONE);
    ex_regwen = 1; id_rt_ren = 0;
    #1 chk("lu_noren", obs, E_NONE);
    id_rt_ren = 1; i_stall = 1;
    #1 chk("lu_over_ist", obs, E_LU);
    ex_load = 0;
    #1 chk("ist", obs, E_IST);
    clr();
    d_stall = 1; exc_flush = 1;
    #1 chk("fls_over_dst", obs, E_FLS);
    exc_flush = 0;
    #1 chk("dst", obs, 10'b00_1111_0000);
    clr();
    step();

    // div: 33 busy cycles then DONE releases EX
    ex_div = 1;
    busy_n = 0;
    for (int i = 0; i < 33; i++) begin
      #1 chk(i == 0 ? "div_start" : "div_busy", obs,
             i == 0 ? E_START : E_BUSY);
      if (md_busy) busy_n++;
      step();
    end
    #1 chk("div_done", obs, E_NONE);
    chk("div_cycles", busy_n, 33);
    step();
    ex_div = 0;
    #1 chk("div_idle", obs, E_NONE);
    step();

    // mult with a 3-cycle memory wait on busy cycle 2
    ex_mult = 1;
    busy_n = 0;
    #1 chk("mul_start", obs, E_START);
    if (md_busy) busy_n++;
    step();
    d_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("mul_dstall", obs, E_BDST);
      if (md_busy) busy_n++;
      step();
    end
    d_stall = 0;
    #1 chk("mul_busy", obs, E_BUSY);
    if (md_busy) busy_n++;
    step();
    #1 chk("mul_done", obs, E_NONE);
    chk("mul_cycles", busy_n, 5);
    step();
    ex_mult = 0;
    step();

    // flush on div busy cycle 10
    ex_div = 1;
    for (int i = 0; i < 9; i++) step();
    exc_flush = 1;
    #1 chk("div_flush", obs, E_BFLS);
    step();
    exc_flush = 0; ex_div = 0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("post_flush", obs, E_NONE);
      step();
    end
    ex_div = 1;
    #1 chk("relaunch_fl", obs, E_START);
    step();
    flush_fsm();
    step();

    // async reset on div busy cycle 5
    ex_div = 1;
    for (int i = 0; i < 4; i++) step();
    #1 chk("div_b5", obs, E_BUSY);
    resetn = 0;
    #1 chk("rst_mid", obs, E_RST);
    step();
    ex_div = 0;
    #1 resetn = 1;
    #1 chk("post_rst", obs, E_NONE);
    step();
    #1 chk("post_rst2", obs, E_NONE);
    ex_div = 1;
    #1 chk("relaunch_rst", obs, E_START);
    step();
    flush_fsm();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
